// File: rtl/memory_test_hw_pkg.sv
// Shared encodings and constants for the hardware RAM tester: pattern
// selection, controller states and the Galois LFSR used by the LFSR pattern.
package memory_test_hw_pkg;

    typedef enum logic [1:0] {
        PAT_ADDR    = 2'd0,
        PAT_WALK    = 2'd1,
        PAT_LFSR    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is swapped for this.
    localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/memory_test_hw_pattern_gen.sv
// Test-pattern generator: produces the expected word for the current address.
// Only the LFSR pattern carries state; restart reloads it from the seed.
module memory_test_hw_pattern_gen
    import memory_test_hw_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              advance,
    input  pattern_e          pattern_sel,
    input  logic [31:0]       seed,
    input  logic [ADDR_W-1:0] index,
    output logic [31:0]       word
);

    logic [31:0] lfsr_q, lfsr_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        lfsr_d = lfsr_q;
        if (restart) begin
            lfsr_d = (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_ZERO_SUB;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        word = '0;
        case (pattern_sel)
            PAT_ADDR:    word[ADDR_W-1:0] = index;
            PAT_WALK:    word = 32'h1 << index[4:0];
            PAT_LFSR:    word = lfsr_q;
            PAT_CHECKER: word = index[0] ? ~seed : seed;
            default:     word = '0;
        endcase
    end

endmodule

// File: rtl/memory_test_hw_ram_tester.sv
// Avalon-MM master that fills an address range with a pattern, reads it back,
// and reports pass/fail, a saturating error count and the first bad location.
module memory_test_hw_ram_tester
    import memory_test_hw_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        pattern_sel,
    input  logic [31:0]       seed,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   start_q, end_q;
    logic [31:0]         seed_q;
    pattern_e            pat_q;
    logic [DATA_W-1:0]   exp_q;
    logic [ADDR_W-1:0]   exp_addr_q;
    logic                cmp_valid_q;
    logic [ERR_W-1:0]    err_q;
    logic [ADDR_W-1:0]   ferr_addr_q;
    logic [DATA_W-1:0]   ferr_data_q;
    logic                range_err_q;

    logic                idle_like, accept, last, mismatch;
    logic                gen_restart, gen_advance;
    logic [31:0]         gen_seed, gen_word;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = start && !abort && idle_like;
    assign last      = (addr_q == end_q);
    assign mismatch  = cmp_valid_q && (readdata != exp_q);

    // The generator restarts from the raw seed on start (seed_q is not loaded
    // yet) and from the latched seed when switching from write to read.
    assign gen_restart = accept || (state_q == ST_WRITE && last && !abort);
    assign gen_advance = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign gen_seed    = accept ? seed : seed_q;

    memory_test_hw_pattern_gen #(.ADDR_W(ADDR_W)) u_pattern_gen (
        .clk         (clk),
        .reset       (reset),
        .restart     (gen_restart),
        .advance     (gen_advance),
        .pattern_sel (pat_q),
        .seed        (gen_seed),
        .index       (addr_q),
        .word        (gen_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = (start_addr > end_addr) ? ST_DONE : ST_WRITE;
                ST_WRITE:         if (last) state_d = ST_READ;
                ST_READ:          if (last) state_d = ST_DRAIN;
                ST_DRAIN:         state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        chipselect = (state_q == ST_WRITE) || (state_q == ST_READ);
        write      = (state_q == ST_WRITE);
        byteenable = chipselect ? 4'hF : 4'h0;
        writedata  = write ? gen_word : '0;
        busy       = chipselect || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        pass       = done && (err_q == '0) && !range_err_q;
    end

    // Comparing for equality before incrementing keeps the counter from
    // wrapping when end_addr is the top of memory.
    always_comb begin
        addr_d = addr_q;
        if (accept) begin
            addr_d = start_addr;
        end else if (state_q == ST_WRITE && last) begin
            addr_d = start_q;
        end else if ((state_q == ST_WRITE || state_q == ST_READ) && !last) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            seed_q      <= '0;
            pat_q       <= PAT_ADDR;
            exp_q       <= '0;
            exp_addr_q  <= '0;
            cmp_valid_q <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            range_err_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            exp_q       <= gen_word;
            exp_addr_q  <= addr_q;
            cmp_valid_q <= (state_q == ST_READ) && !abort;
            if (accept) begin
                start_q     <= start_addr;
                end_q       <= end_addr;
                seed_q      <= seed;
                pat_q       <= pattern_e'(pattern_sel);
                err_q       <= '0;
                ferr_addr_q <= '0;
                ferr_data_q <= '0;
                range_err_q <= (start_addr > end_addr);
            end else if (mismatch) begin
                if (err_q != {ERR_W{1'b1}}) err_q <= err_q + 1'b1;
                if (err_q == '0) begin
                    ferr_addr_q <= exp_addr_q;
                    ferr_data_q <= readdata;
                end
            end
        end
    end

    assign address        = addr_q;
    assign range_err      = range_err_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_memory_test_hw_ram_tester.sv
// Directed bench for the RAM tester: a behavioural RAM with optional read faults,
// plus a second tester with a 4-bit error counter fed all-zero read data.
module tb_memory_test_hw_ram_tester;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [1:0]  pattern_sel;
    logic [31:0] seed;
    logic [14:0] start_addr, end_addr;

    logic [14:0] address, first_err_addr;
    logic [3:0]  byteenable;
    logic        chipselect, write, busy, done, pass, range_err;
    logic [31:0] writedata, readdata, first_err_data;
    logic [15:0] err_count;

    logic [14:0] s_address, s_first_err_addr;
    logic [3:0]  s_byteenable, s_err_count;
    logic        s_chipselect, s_write, s_busy, s_done, s_pass, s_range_err;
    logic [31:0] s_writedata, s_first_err_data;

    int          checks = 0;
    int          failures = 0;
    int          fault_mode = 0;
    int          cyc;
    logic        cs_seen;
    logic [31:0] wd_log [1:5];
    logic [14:0] addr1;

    always #5 clk = ~clk;

    memory_test_hw_ram_tester u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern_sel(pattern_sel), .seed(seed), .start_addr(start_addr), .end_addr(end_addr),
        .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(readdata), .busy(busy), .done(done), .pass(pass),
        .range_err(range_err), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    memory_test_hw_ram_tester #(.ERR_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern_sel(pattern_sel), .seed(seed), .start_addr(start_addr), .end_addr(end_addr),
        .address(s_address), .byteenable(s_byteenable), .chipselect(s_chipselect), .write(s_write),
        .writedata(s_writedata), .readdata(32'h0), .busy(s_busy), .done(s_done), .pass(s_pass),
        .range_err(s_range_err), .err_count(s_err_count), .first_err_addr(s_first_err_addr),
        .first_err_data(s_first_err_data)
    );

    // NOTE: the RAM array is deliberately not reset; every location is written
    // before it is read, exactly as with the real on-chip RAM.
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write) begin
            if (fault_mode == 2)                             readdata <= 32'h0;
            else if (fault_mode == 1 && address == 15'h0005) readdata <= mem[address] ^ 32'h1;
            else                                             readdata <= mem[address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulses start in cycle 0 and samples at each negedge until done or the budget runs out.
    task automatic run(input logic [1:0] sel, input logic [31:0] sd, input logic [14:0] sa,
                       input logic [14:0] ea, input int limit);
        @(negedge clk);
        pattern_sel = sel; seed = sd; start_addr = sa; end_addr = ea; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; cs_seen = chipselect; addr1 = address; wd_log[1] = writedata;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (chipselect) cs_seen = 1'b1;
            if (cyc <= 5) wd_log[cyc] = writedata;
        end
        check("done_within_budget", {31'b0, done}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern_sel = 2'd0; seed = '0; start_addr = '0; end_addr = '0; readdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_we_busy", {28'b0, chipselect, write, busy, done}, 32'h0);
        check("rst_pass_rerr", {30'b0, pass, range_err}, 32'h0);
        check("rst_byteenable", {28'b0, byteenable}, 32'h0);
        check("rst_address", {17'b0, address}, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_err_count", {16'b0, err_count}, 32'h0);
        check("rst_first_err", {17'b0, first_err_addr} | first_err_data, 32'h0);
        reset = 1'b0;

        // Address pattern over 16 words, clean RAM.
        run(2'd0, 32'h0, 15'h0000, 15'h000F, 200);
        check("addr_cycle1_cs", {31'b0, cs_seen}, 32'h1);
        check("addr_cycle1_addr", {17'b0, addr1}, 32'h0);
        check("addr_wd2", wd_log[2], 32'h1);
        check("addr_wd5", wd_log[5], 32'h4);
        check("addr_done_cycle", cyc, 34);
        check("addr_pass", {31'b0, pass}, 32'h1);
        check("addr_err_count", {16'b0, err_count}, 32'h0);

        // Checkerboard with bit 0 flipped on reads of address 5.
        fault_mode = 1;
        run(2'd3, 32'hA5A5_A5A5, 15'h0000, 15'h000F, 200);
        check("chk_wd1", wd_log[1], 32'hA5A5_A5A5);
        check("chk_wd2", wd_log[2], 32'h5A5A_5A5A);
        check("chk_done_cycle", cyc, 34);
        check("chk_err_count", {16'b0, err_count}, 32'h1);
        check("chk_first_addr", {17'b0, first_err_addr}, 32'h5);
        check("chk_first_data", first_err_data, 32'h5A5A_5A5B);
        check("chk_pass", {31'b0, pass}, 32'h0);
        fault_mode = 0;

        // Inverted range: finishes immediately with no bus traffic.
        run(2'd0, 32'h0, 15'h0010, 15'h000F, 20);
        check("range_done_cycle", cyc, 1);
        check("range_err", {31'b0, range_err}, 32'h1);
        check("range_pass", {31'b0, pass}, 32'h0);
        check("range_no_cs", {31'b0, cs_seen}, 32'h0);
        check("range_err_count_cleared", {16'b0, err_count}, 32'h0);

        // Walking ones, aborted in cycle 100, then rerun to completion.
        @(negedge clk);
        pattern_sel = 2'd1; seed = 32'h0; start_addr = 15'h0000; end_addr = 15'h00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("walk_wd1", writedata, 32'h1);
        @(negedge clk);
        check("walk_wd2", writedata, 32'h2);
        repeat (97) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cs", {31'b0, chipselect}, 32'h0);
        check("abort_busy_done", {30'b0, busy, done}, 32'h0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {30'b0, busy, done}, 32'h0);
        run(2'd1, 32'h0, 15'h0000, 15'h00FF, 1000);
        check("walk_done_cycle", cyc, 514);
        check("walk_pass", {31'b0, pass}, 32'h1);

        // Simultaneous start and abort: abort wins, nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {29'b0, busy, chipselect, done}, 32'h0);

        // Stuck-at-zero reads: address 0 matches, the other 31 words fail.
        fault_mode = 2;
        run(2'd0, 32'h0, 15'h0000, 15'h001F, 200);
        check("stuck_done_cycle", cyc, 66);
        check("stuck_err_count", {16'b0, err_count}, 32'h1F);
        check("stuck_first_addr", {17'b0, first_err_addr}, 32'h1);
        check("stuck_first_data", first_err_data, 32'h0);
        check("stuck_pass", {31'b0, pass}, 32'h0);
        check("sat_err_count", {28'b0, s_err_count}, 32'hF);
        check("sat_first_addr", {17'b0, s_first_err_addr}, 32'h1);
        fault_mode = 0;

        // LFSR over the full 32768-word range.
        run(2'd2, 32'h1234_5678, 15'h0000, 15'h7FFF, 70000);
        check("lfsr_wd1", wd_log[1], 32'h1234_5678);
        check("lfsr_wd2", wd_log[2], 32'h091A_2B3C);
        check("lfsr_wd3", wd_log[3], 32'h048D_159E);
        check("lfsr_wd4", wd_log[4], 32'h0246_8ACF);
        check("lfsr_wd5", wd_log[5], 32'h8103_4564);
        check("lfsr_done_cycle", cyc, 65538);
        check("lfsr_pass", {31'b0, pass}, 32'h1);
        check("lfsr_err_count", {16'b0, err_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
